pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Hazard and stall controller that drives the write-enable side of the program counter and IF/ID pipeline register in the five-stage core. It decides each cycle whether the PC loads its next address, whether IF/ID holds, and whether bubbles or flushes are injected. It covers load-use hazards, taken-branch flushes, and fixed-latency multi-cycle (mult/div) stalls. A saturating counter records stall cycles for performance measurement.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width
- MC_LATENCY, 4, total stall cycles for a multi-cycle op; legal range ≥ 2
- CNT_W, 3, width of the multi-cycle down-counter; must hold MC_LATENCY-1

Ports:
- Clk  in  1  clock
- Reset  in  1  reset Reset, asynchronous, active-high
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_Rt  in  REG_ADDR_W  load destination register in EX
- IFID_Rs  in  REG_ADDR_W  source register of instruction in ID
- IFID_Rt  in  REG_ADDR_W  second source register of instruction in ID
- IFID_UsesRt  in  1  ID instruction reads Rt as a source
- EX_BranchTaken  in  1  branch/jump in EX resolved taken
- ID_MultiStart  in  1  ID instruction is a multi-cycle op
- PC_Write  out  1  PC load enable
- IFID_Write  out  1  IF/ID load enable
- IDEX_Bubble  out  1  zero control fields entering ID/EX
- IFID_Flush  out  1  replace IF/ID contents with NOP
- Busy  out  1  FSM not in RUN
- StallCycles  out  32  count of cycles with PC_Write=0

## Operation
- **Load-use hazard (LU):** IDEX_MemRead=1, IDEX_Rt≠0, and either IDEX_Rt==IFID_Rs, or IFID_UsesRt=1 with IDEX_Rt==IFID_Rt.
- **Stall outputs:** PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
- **Flush outputs:** PC_Write=1, IFID_Write=1, IDEX_Bubble=1, IFID_Flush=1.
- **Normal outputs:** PC_Write=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0.
- **Priority in every state:** EX_BranchTaken > multi-cycle > LU > normal.

FSM states:
- **RUN**
  - Branch: flush outputs; stay in RUN.
  - Else ID_MultiStart: stall outputs; cnt←MC_LATENCY-1; go to MC_WAIT.
  - Else LU: stall outputs; stay in RUN.
  - Else: normal outputs.
- **MC_WAIT**
  - Branch: flush outputs; cnt←0; go to RUN.
  - Else: stall outputs. If cnt==1, go to MC_RELEASE; else cnt←cnt-1.
- **MC_RELEASE**
  - ID_MultiStart is ignored, because the same instruction is still in ID.
  - Branch: flush outputs; go to RUN.
  - Else LU: stall outputs; stay in MC_RELEASE.
  - Else: normal outputs; go to RUN.

Other rules:
- Busy = (state≠RUN).
- StallCycles increments on every clock edge where PC_Write=0, and saturates at 32'hFFFFFFFF.

## Timing
- Control outputs are Mealy and combinational from the current state and current inputs. They take effect at the same edge that updates the PC and IF/ID registers.
- State, cnt and StallCycles are registered on posedge Clk.
- A multi-cycle op produces exactly MC_LATENCY consecutive stall cycles. It starts the cycle ID_MultiStart is first seen in RUN; the op advances on the following edge, absent branch or LU.
- LU stalls last exactly 1 cycle, because the bubble clears IDEX_MemRead.
- Reset asserted:
  - Asynchronously, state=RUN, cnt=0, StallCycles=0.
  - Outputs forced to PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=1, Busy=0.
  - Forced stalls during reset do not count toward StallCycles.
- Reset mid-MC_WAIT aborts the stall; the first post-reset cycle behaves as RUN.
- Branch and LU in the same cycle: flush wins; the LU is discarded with the flushed instruction.

## Structure
- Shared package (pipeline_pkg):
  - State enum: RUN, MC_WAIT, MC_RELEASE.
  - REG_ADDR_W.
  - Zero-register constant.
- Sub-module load_use_detect: purely combinational LU comparator, reusable by the forwarding unit.
- Target size is roughly 150 lines of RTL.

## Test plan
- **Load-use on Rs:** IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5.
  - Exactly one cycle of PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  - StallCycles goes 0→1.
- **Register zero and unused Rt:**
  - IDEX_Rt=0, IFID_Rs=0 → no stall.
  - IDEX_Rt=7, IFID_Rt=7, IFID_UsesRt=0 → no stall.
- **Multi-cycle op, MC_LATENCY=4:** ID_MultiStart held high.
  - PC_Write=0 for 4 consecutive cycles, Busy=1 for cycles 2–5.
  - Fifth cycle: normal outputs, state back to RUN, StallCycles=4.
- **Branch vs. hazards:**
  - EX_BranchTaken=1 together with LU → flush outputs, no stall.
  - EX_BranchTaken=1 during MC_WAIT → flush, Busy=0 next cycle.
- **Reset mid-stall:** assert Reset asynchronously in MC_WAIT.
  - Immediately: Busy=0, StallCycles=0, IFID_Flush=1.
  - After release with idle inputs: normal outputs.
- **Saturation:** force StallCycles near 32'hFFFFFFFE, stall 3 cycles → holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall control slice.
package pipeline_pkg;

  localparam int unsigned PIPE_REG_ADDR_W = 5;

  // Architectural zero register: never a real dependency.
  localparam logic [PIPE_REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MC_WAIT    = 2'd1,
    MC_RELEASE = 2'd2
  } stall_state_e;

  // Control bundle driven toward the PC and IF/ID / ID/EX registers.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
  } stall_ctrl_t;

  localparam stall_ctrl_t CTRL_NORMAL = stall_ctrl_t'(4'b1100);
  localparam stall_ctrl_t CTRL_STALL  = stall_ctrl_t'(4'b0010);
  localparam stall_ctrl_t CTRL_FLUSH  = stall_ctrl_t'(4'b1111);
  localparam stall_ctrl_t CTRL_RESET  = stall_ctrl_t'(4'b0011);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator; shared with the forwarding unit.
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = PIPE_REG_ADDR_W
) (
  input  logic                  MemRead,
  input  logic [REG_ADDR_W-1:0] LoadRt,
  input  logic [REG_ADDR_W-1:0] Rs,
  input  logic [REG_ADDR_W-1:0] Rt,
  input  logic                  UsesRt,
  output logic                  Hazard
);

  logic dest_live;
  logic rs_match;
  logic rt_match;

  // A load to r0 never creates a dependency; Rt only matters when it is read.
  always_comb begin
    dest_live = (LoadRt != REG_ADDR_W'(ZERO_REG));
    rs_match  = (LoadRt == Rs);
    rt_match  = UsesRt && (LoadRt == Rt);
    Hazard    = MemRead && dest_live && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// PC / IF/ID write-enable controller: load-use stalls, branch flushes,
// fixed-latency multi-cycle stalls, plus a saturating stall-cycle counter.
module pipeline_stall_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = PIPE_REG_ADDR_W,
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  input  logic [REG_ADDR_W-1:0] IFID_Rs,
  input  logic [REG_ADDR_W-1:0] IFID_Rt,
  input  logic                  IFID_UsesRt,
  input  logic                  EX_BranchTaken,
  input  logic                  ID_MultiStart,
  output logic                  PC_Write,
  output logic                  IFID_Write,
  output logic                  IDEX_Bubble,
  output logic                  IFID_Flush,
  output logic                  Busy,
  output logic [31:0]           StallCycles
);

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  stall_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q;
  stall_ctrl_t      ctrl;
  logic             lu_hazard;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu (
    .MemRead (IDEX_MemRead),
    .LoadRt  (IDEX_Rt),
    .Rs      (IFID_Rs),
    .Rt      (IFID_Rt),
    .UsesRt  (IFID_UsesRt),
    .Hazard  (lu_hazard)
  );

  // State and multi-cycle down-counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Mealy control outputs; priority branch > multi-cycle > LU.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_NORMAL;
    if (Reset) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_q)
        RUN: begin
          if (EX_BranchTaken) begin
            ctrl = CTRL_FLUSH;
          end else if (ID_MultiStart) begin
            ctrl    = CTRL_STALL;
            cnt_d   = CNT_W'(MC_LATENCY - 1);
            state_d = MC_WAIT;
          end else if (lu_hazard) begin
            ctrl = CTRL_STALL;
          end
        end
        MC_WAIT: begin
          if (EX_BranchTaken) begin
            ctrl    = CTRL_FLUSH;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            ctrl = CTRL_STALL;
            if (cnt_q == CNT_W'(1)) begin
              state_d = MC_RELEASE;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        MC_RELEASE: begin
          // The finished multi-cycle op is still in ID, so its start flag is ignored.
          if (EX_BranchTaken) begin
            ctrl    = CTRL_FLUSH;
            state_d = RUN;
          end else if (lu_hazard) begin
            ctrl = CTRL_STALL;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt_q <= '0;
    end else if (!ctrl.pc_write && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  // Output mapping.
  always_comb begin
    PC_Write    = ctrl.pc_write;
    IFID_Write  = ctrl.ifid_write;
    IDEX_Bubble = ctrl.idex_bubble;
    IFID_Flush  = ctrl.ifid_flush;
    Busy        = (state_q != RUN);
    StallCycles = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller against a behavioural model.
module tb_pipeline_stall_controller;

  localparam int unsigned RW  = 5;
  localparam int unsigned LAT = 4;

  logic          Clk;
  logic          Reset;
  logic          IDEX_MemRead;
  logic [RW-1:0] IDEX_Rt;
  logic [RW-1:0] IFID_Rs;
  logic [RW-1:0] IFID_Rt;
  logic          IFID_UsesRt;
  logic          EX_BranchTaken;
  logic          ID_MultiStart;
  logic          PC_Write;
  logic          IFID_Write;
  logic          IDEX_Bubble;
  logic          IFID_Flush;
  logic          Busy;
  logic [31:0]   StallCycles;

  int checks;
  int failures;

  // Model: remaining multi-cycle stall cycles and "finished op still in ID" flag.
  int              mc_left;
  bit              mc_release;
  longint unsigned m_stall;
  int              n_left;
  bit              n_release;
  logic [3:0]      exp_ctrl;
  logic            exp_busy;

  pipeline_stall_controller #(
    .REG_ADDR_W (RW),
    .MC_LATENCY (LAT),
    .CNT_W      (3)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .IDEX_MemRead   (IDEX_MemRead),
    .IDEX_Rt        (IDEX_Rt),
    .IFID_Rs        (IFID_Rs),
    .IFID_Rt        (IFID_Rt),
    .IFID_UsesRt    (IFID_UsesRt),
    .EX_BranchTaken (EX_BranchTaken),
    .ID_MultiStart  (ID_MultiStart),
    .PC_Write       (PC_Write),
    .IFID_Write     (IFID_Write),
    .IDEX_Bubble    (IDEX_Bubble),
    .IFID_Flush     (IFID_Flush),
    .Busy           (Busy),
    .StallCycles    (StallCycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void model_clear();
    mc_left    = 0;
    mc_release = 1'b0;
    m_stall    = 0;
  endfunction

  // Expected outputs for the current cycle and the model's next state.
  function automatic void model_eval();
    bit lu;
    lu = IDEX_MemRead && (IDEX_Rt != 0) &&
         ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    exp_busy = (mc_left > 0) || mc_release;
    if (Reset) begin
      exp_ctrl = 4'b0011; n_left = 0; n_release = 1'b0; exp_busy = 1'b0;
    end else if (EX_BranchTaken) begin
      exp_ctrl = 4'b1111; n_left = 0; n_release = 1'b0;
    end else if (mc_left > 0) begin
      exp_ctrl = 4'b0010; n_left = mc_left - 1; n_release = (n_left == 0);
    end else if (ID_MultiStart && !mc_release) begin
      exp_ctrl = 4'b0010; n_left = LAT - 1; n_release = 1'b0;
    end else if (lu) begin
      exp_ctrl = 4'b0010; n_left = 0; n_release = mc_release;
    end else begin
      exp_ctrl = 4'b1100; n_left = 0; n_release = 1'b0;
    end
  endfunction

  task automatic drive(input bit rst, input bit mr, input int lrt, input int rs,
                       input int rt, input bit uses, input bit br, input bit mul);
    @(negedge Clk);
    Reset          = rst;
    IDEX_MemRead   = mr;
    IDEX_Rt        = RW'(lrt);
    IFID_Rs        = RW'(rs);
    IFID_Rt        = RW'(rt);
    IFID_UsesRt    = uses;
    EX_BranchTaken = br;
    ID_MultiStart  = mul;
    #1;
    if (rst) model_clear();
    model_eval();
  endtask

  task automatic advance();
    @(posedge Clk);
    if (!Reset && !exp_ctrl[3] && (m_stall < 64'hFFFF_FFFF)) m_stall++;
    mc_left    = n_left;
    mc_release = n_release;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 5, 5, 0, 0, 0, 1);
      checks++;
      if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Busy} !== 5'b00110) begin
        failures++;
        $display("FAIL reset_ctrl got=%b want=00110",
                 {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Busy});
      end
      advance();
      checks++;
      if (StallCycles !== 32'd0) begin
        failures++;
        $display("FAIL reset_stallcnt got=%0d want=0", StallCycles);
      end
    end
  endtask

  task automatic test_load_use_rs();
    drive(0, 1, 5, 5, 0, 0, 0, 0);
    checks++;
    if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush} !== 4'b0010 ||
        exp_ctrl !== 4'b0010) begin
      failures++;
      $display("FAIL lu_rs_ctrl got=%b want=0010", {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush});
    end
    advance();
    checks++;
    if (StallCycles !== 32'd1) begin
      failures++;
      $display("FAIL lu_rs_count got=%0d want=1", StallCycles);
    end
    drive(0, 0, 5, 5, 0, 0, 0, 0);
    checks++;
    if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush} !== 4'b1100) begin
      failures++;
      $display("FAIL lu_rs_release got=%b want=1100", {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush});
    end
    advance();
  endtask

  task automatic test_reg_zero_unused_rt();
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    checks++;
    if (PC_Write !== 1'b1 || IDEX_Bubble !== 1'b0) begin
      failures++;
      $display("FAIL zero_reg got=%b%b want=10", PC_Write, IDEX_Bubble);
    end
    advance();
    drive(0, 1, 7, 3, 7, 0, 0, 0);
    checks++;
    if (PC_Write !== 1'b1 || IDEX_Bubble !== 1'b0) begin
      failures++;
      $display("FAIL unused_rt got=%b%b want=10", PC_Write, IDEX_Bubble);
    end
    advance();
    drive(0, 1, 7, 3, 7, 1, 0, 0);
    checks++;
    if (PC_Write !== 1'b0 || IDEX_Bubble !== 1'b1) begin
      failures++;
      $display("FAIL used_rt got=%b%b want=01", PC_Write, IDEX_Bubble);
    end
    advance();
  endtask

  task automatic test_multi_cycle();
    longint unsigned base;
    base = m_stall;
    for (int c = 1; c <= LAT + 1; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Busy} !== {exp_ctrl, exp_busy} ||
          PC_Write !== (c > LAT) || Busy !== (c >= 2)) begin
        failures++;
        $display("FAIL multi_cycle c=%0d got=%b want=%b", c,
                 {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Busy}, {exp_ctrl, exp_busy});
      end
      advance();
    end
    checks++;
    if (Busy !== 1'b0 || StallCycles !== 32'(base + LAT)) begin
      failures++;
      $display("FAIL multi_done busy=%b cnt=%0d want busy=0 cnt=%0d", Busy, StallCycles, base + LAT);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_branch();
    drive(0, 1, 4, 4, 0, 0, 1, 0);
    checks++;
    if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush} !== 4'b1111) begin
      failures++;
      $display("FAIL branch_lu got=%b want=1111", {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush});
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if ({PC_Write, IFID_Flush, Busy} !== 3'b111) begin
      failures++;
      $display("FAIL branch_mcwait got=%b want=111", {PC_Write, IFID_Flush, Busy});
    end
    advance();
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL branch_mcwait_busy got=%b want=0", Busy);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    #2;
    Reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if (Busy !== 1'b0 || StallCycles !== 32'd0 || IFID_Flush !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid busy=%b cnt=%0d flush=%b want 0/0/1", Busy, StallCycles, IFID_Flush);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Busy} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_mid_after got=%b want=11000",
               {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Busy});
    end
    advance();
  endtask

  task automatic test_saturation();
    @(negedge Clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    m_stall = 64'hFFFF_FFFD;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 9, 9, 0, 0, 0, 0);
      advance();
      checks++;
      if (StallCycles !== 32'(m_stall)) begin
        failures++;
        $display("FAIL saturation i=%0d got=%h want=%h", i, StallCycles, 32'(m_stall));
      end
    end
    checks++;
    if (StallCycles !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL saturation_final got=%h want=ffffffff", StallCycles);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) == 0), ($urandom_range(1) == 1), $urandom_range(3),
            $urandom_range(3), $urandom_range(3), ($urandom_range(1) == 1),
            ($urandom_range(9) == 0), ($urandom_range(6) == 0));
      checks++;
      if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Busy} !== {exp_ctrl, exp_busy}) begin
        failures++;
        $display("FAIL random_ctrl i=%0d got=%b want=%b", i,
                 {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Busy}, {exp_ctrl, exp_busy});
      end
      advance();
      checks++;
      if (StallCycles !== 32'(m_stall)) begin
        failures++;
        $display("FAIL random_count i=%0d got=%0d want=%0d", i, StallCycles, m_stall);
      end
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    Reset          = 1'b1;
    IDEX_MemRead   = 1'b0;
    IDEX_Rt        = '0;
    IFID_Rs        = '0;
    IFID_Rt        = '0;
    IFID_UsesRt    = 1'b0;
    EX_BranchTaken = 1'b0;
    ID_MultiStart  = 1'b0;
    model_clear();
    test_reset();
    test_load_use_rs();
    test_reg_zero_unused_rt();
    test_multi_cycle();
    test_branch();
    test_reset_mid_stall();
    test_saturation();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    advance();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
